// File: rtl/program_loader_if.sv
// Handshake and status signals between the boot loader and the rest of the CPU top level.
// The shared tristate bus and control word remain plain ports on the loader.
interface program_loader_if;
    logic       start;
    logic [4:0] prog_length;
    logic [7:0] prog_word;
    logic [3:0] prog_addr;
    logic       decoder_enable;
    logic       cpu_clear;
    logic       busy;
    logic       done;

    modport master (
        input  start, prog_length, prog_word,
        output prog_addr, decoder_enable, cpu_clear, busy, done
    );

    modport slave (
        output start, prog_length, prog_word,
        input  prog_addr, decoder_enable, cpu_clear, busy, done
    );
endinterface

// File: rtl/program_loader.sv
// Boot-time sequencer: copies up to 16 program bytes into RAM over the shared bus,
// pulses a CPU-wide clear, then hands control-word ownership to the instruction decoder.
//
// state   | meaning
// IDLE    | after reset, bus released, control word held at 0
// ADDR    | drive load address on bus, assert MAR load
// DATA    | drive program byte on bus, assert RAM write
// HANDOFF | one-cycle cpu_clear, control word still held at 0
// RUN     | decoder owns the control word, loader fully released
module program_loader #(
    parameter int MAR_IN_BIT = 0,
    parameter int RAM_IN_BIT = 1
) (
    input  logic                  clk,
    input  logic                  clear,
    program_loader_if.master      ctl,
    output logic [7:0]            bus_out,
    output logic [15:0]           control_word_out
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_HANDOFF = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;

    localparam logic [15:0] CW_MAR = 16'd1 << MAR_IN_BIT;
    localparam logic [15:0] CW_RAM = 16'd1 << RAM_IN_BIT;

    logic [2:0]  state;
    logic [3:0]  addr;
    logic [3:0]  last;
    logic        empty;
    logic [4:0]  len_clamped;
    logic        len_zero;

    logic        bus_drive;
    logic [7:0]  bus_val;
    logic        cw_drive;
    logic [15:0] cw_val;

    assign len_clamped = (ctl.prog_length > 5'd16) ? 5'd16 : ctl.prog_length;
    assign len_zero    = (len_clamped == 5'd0);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= S_IDLE;
            addr  <= 4'd0;
            last  <= 4'd0;
            empty <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_RUN: begin
                    if (ctl.start) begin
                        addr  <= 4'd0;
                        // a length of 16 wraps to 15 here, which is exactly the last address
                        last  <= len_clamped[3:0] - 4'd1;
                        empty <= len_zero;
                        state <= len_zero ? S_HANDOFF : S_ADDR;
                    end
                end
                S_ADDR: state <= S_DATA;
                S_DATA: begin
                    if (addr == last || empty) begin
                        state <= S_HANDOFF;
                    end else begin
                        addr  <= addr + 4'd1;
                        state <= S_ADDR;
                    end
                end
                S_HANDOFF: state <= S_RUN;
                default:   state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus_drive = 1'b0;
        bus_val   = 8'h00;
        cw_drive  = 1'b1;
        cw_val    = 16'h0000;
        case (state)
            S_ADDR: begin
                bus_drive = 1'b1;
                bus_val   = {4'b0000, addr};
                cw_val    = CW_MAR;
            end
            S_DATA: begin
                bus_drive = 1'b1;
                bus_val   = ctl.prog_word;
                cw_val    = CW_RAM;
            end
            S_RUN:   cw_drive = 1'b0;
            default: ;
        endcase
    end

    assign bus_out          = bus_drive ? bus_val : 8'bz;
    assign control_word_out = cw_drive ? cw_val : 16'bz;

    assign ctl.prog_addr      = addr;
    assign ctl.decoder_enable = (state == S_RUN);
    assign ctl.done           = (state == S_RUN);
    assign ctl.cpu_clear      = (state == S_HANDOFF);
    assign ctl.busy           = (state == S_ADDR) || (state == S_DATA) || (state == S_HANDOFF);

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: loads push expected MAR/RAM/clear events,
// a negedge monitor pops and compares whenever the loader asserts one.
module tb_program_loader;

    localparam logic [15:0] MASK_MAR = 16'h0001;
    localparam logic [15:0] MASK_RAM = 16'h0002;
    localparam int K_MAR = 0;
    localparam int K_RAM = 1;
    localparam int K_CLR = 2;

    typedef struct {
        int         kind;
        logic [7:0] bus;
        logic [3:0] addr;
    } ev_t;

    logic        clk;
    logic        clear;
    wire  [7:0]  bus_out;
    wire  [15:0] cw;
    logic [7:0]  src [16];
    ev_t         exp_q [$];
    int          checks;
    int          failures;

    program_loader_if ifc ();

    assign ifc.prog_word = src[ifc.prog_addr];

    program_loader #(.MAR_IN_BIT(0), .RAM_IN_BIT(1)) dut (
        .clk              (clk),
        .clear            (clear),
        .ctl              (ifc),
        .bus_out          (bus_out),
        .control_word_out (cw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit released8(input logic [7:0] v);
        return (v === 8'bz) || (v === 8'h00);
    endfunction

    function automatic bit released16(input logic [15:0] v);
        return (v === 16'bz) || (v === 16'h0000);
    endfunction

    function automatic int clamp_len(input int len);
        return (len > 16) ? 16 : len;
    endfunction

    // Expected event stream of a load: one (MAR, RAM) pair per byte, then the clear pulse.
    task automatic push_load(input int len, input int max_ev);
        int n;
        int cnt;
        ev_t e;
        n   = clamp_len(len);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (cnt < max_ev) begin
                e.kind = K_MAR; e.bus = 8'(i); e.addr = 4'(i);
                exp_q.push_back(e); cnt++;
            end
            if (cnt < max_ev) begin
                e.kind = K_RAM; e.bus = src[i]; e.addr = 4'(i);
                exp_q.push_back(e); cnt++;
            end
        end
        if (cnt < max_ev) begin
            e.kind = K_CLR; e.bus = 8'h00; e.addr = 4'(n == 0 ? 0 : n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        int  kind;
        ev_t e;
        if (!clear) begin
            kind = -1;
            if (ifc.cpu_clear === 1'b1) kind = K_CLR;
            else if (cw === MASK_MAR) kind = K_MAR;
            else if (cw === MASK_RAM) kind = K_RAM;

            checks++;
            if (!(released16(cw) || cw === MASK_MAR || cw === MASK_RAM)) begin
                failures++;
                $display("FAIL cw_legal: got %0h", cw);
            end

            if (kind >= 0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event: kind %0d addr %0h bus %0h", kind, ifc.prog_addr, bus_out);
                end else begin
                    e = exp_q.pop_front();
                    if (kind != e.kind || ifc.prog_addr !== e.addr ||
                        (kind != K_CLR && bus_out !== e.bus) ||
                        (kind == K_CLR && (cw !== 16'h0000 || ifc.busy !== 1'b1 || ifc.decoder_enable !== 1'b0))) begin
                        failures++;
                        $display("FAIL event: got kind %0d addr %0h bus %0h cw %0h, expected kind %0d addr %0h bus %0h",
                                 kind, ifc.prog_addr, bus_out, cw, e.kind, e.addr, e.bus);
                    end
                end
            end

            if (ifc.decoder_enable === 1'b1) begin
                checks++;
                if (!released16(cw) || !released8(bus_out) || ifc.busy !== 1'b0 || ifc.done !== 1'b1) begin
                    failures++;
                    $display("FAIL run_release: cw %0h bus %0h busy %0b done %0b", cw, bus_out, ifc.busy, ifc.done);
                end
            end
        end
    end

    // Drive start for one edge; returns at the first negedge after the sampling edge.
    task automatic start_load(input int len);
        @(negedge clk);
        ifc.start       = 1'b1;
        ifc.prog_length = 5'(len);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Count cycles from the sampling edge until decoder_enable; optionally glitch start mid-load.
    task automatic wait_run(input int len, input int glitch, input bit hold);
        int n;
        n = 1;
        while (ifc.decoder_enable !== 1'b1 && n < 200) begin
            if (!hold) begin
                ifc.start = (n == glitch);
                ifc.prog_length = 5'($urandom);
            end
            @(negedge clk);
            n++;
        end
        if (!hold) ifc.start = 1'b0;
        check("handoff_latency", 32'(n), 32'(2 * clamp_len(len) + 2));
        check("done_in_run", 32'(ifc.done), 32'd1);
    endtask

    task automatic run_load(input int len, input int glitch);
        push_load(len, 1000);
        start_load(len);
        wait_run(len, glitch, 1'b0);
    endtask

    task automatic rand_src();
        for (int i = 0; i < 16; i++) src[i] = 8'($urandom);
    endtask

    initial begin
        int len;
        int gl;
        checks          = 0;
        failures        = 0;
        clear           = 1'b1;
        ifc.start       = 1'b0;
        ifc.prog_length = 5'd0;
        rand_src();
        repeat (3) @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(ifc.busy), 32'd0);
        check("reset_done", 32'(ifc.done), 32'd0);
        check("reset_dec_en", 32'(ifc.decoder_enable), 32'd0);
        check("reset_cpu_clear", 32'(ifc.cpu_clear), 32'd0);
        check("reset_cw", 32'(cw), 32'd0);
        check("reset_bus_released", 32'(released8(bus_out)), 32'd1);
        check("reset_prog_addr", 32'(ifc.prog_addr), 32'd0);

        src[0] = 8'h1E; src[1] = 8'h2F; src[2] = 8'hE0;
        run_load(3, 0);
        run_load(0, 0);
        rand_src();
        run_load(20, 0);
        rand_src();
        run_load(1, 0);

        // clear during DATA of byte 2
        rand_src();
        push_load(5, 4);
        start_load(5);
        ifc.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 clear = 1'b1;
        #1;
        check("clear_busy", 32'(ifc.busy), 32'd0);
        check("clear_dec_en", 32'(ifc.decoder_enable), 32'd0);
        check("clear_cw", 32'(cw), 32'd0);
        check("clear_bus_released", 32'(released8(bus_out)), 32'd1);
        check("clear_prog_addr", 32'(ifc.prog_addr), 32'd0);
        #1 clear = 1'b0;
        rand_src();
        run_load(6, 0);

        rand_src();
        run_load(4, 3);

        // start held high through a load: reload after exactly one RUN cycle
        rand_src();
        push_load(2, 1000);
        push_load(2, 1000);
        start_load(2);
        wait_run(2, 0, 1'b1);
        @(negedge clk);
        check("held_reload_dec_en", 32'(ifc.decoder_enable), 32'd0);
        check("held_reload_busy", 32'(ifc.busy), 32'd1);
        wait_run(2, 0, 1'b0);

        for (int t = 0; t < 8; t++) begin
            rand_src();
            len = int'($urandom_range(0, 31));
            gl  = 0;
            if (clamp_len(len) >= 2) gl = 2 * int'($urandom_range(0, clamp_len(len) - 1)) + 1;
            run_load(len, gl);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time sequencer that owns the shared 8-bit bus and the 16-bit control word while the instruction decoder is disabled. It copies a program of up to 16 bytes from an external program source into RAM, using the memory address register and RAM as the datapath. It then pulses a CPU-wide clear and hands control-word ownership to the instruction decoder. It sits beside `instruction_decoder` at the top level and drives that block's `enable`.

## Interface
- `MAR_IN_BIT`, default 0: control-word bit index for memory address register load (must match the CW definition).
- `RAM_IN_BIT`, default 1: control-word bit index for RAM write (must match the CW definition).
- `clk` input, 1 bit: system clock. All state changes on the rising edge.
- `clear` input, 1 bit: reset, asynchronous and active-high.
- `start` input, 1 bit: request a (re)load. Sampled on the rising edge.
- `prog_length` input, 5 bits: number of bytes to load. Latched at start. Values above 16 are clamped to 16.
- `prog_word` input, 8 bits: byte at `prog_addr` from the program source (combinational source).
- `prog_addr` output, 4 bits: current load address.
- `bus_out` output, 8 bits: shared bus driver. Set to 8'bz unless the loader drives the bus.
- `control_word_out` output, 16 bits: control word. Set to 16'bz whenever `decoder_enable`=1.
- `decoder_enable` output, 1 bit: connects to `instruction_decoder.enable`. 1 gives the decoder ownership.
- `cpu_clear` output, 1 bit: one-cycle clear pulse to the PC, registers and decoder after loading.
- `busy` output, 1 bit: load in progress.
- `done` output, 1 bit: program loaded and CPU running.

## Operation
- States: IDLE, ADDR, DATA, HANDOFF, RUN. Outputs are Moore, decoded from registered state.
- Registers:
  - `addr`, 4 bits.
  - `last`, 4 bits: last address, equal to clamped length minus 1.
  - `empty`, 1 bit: set when the latched length is 0.
- IDLE:
  - Outputs: `decoder_enable`=0, `control_word_out`=0, `bus_out`=z, `busy`=0, `done`=0.
  - On `start`=1: latch the length and set `addr`=0.
  - If the length is 0, go to HANDOFF. Otherwise go to ADDR.
- ADDR:
  - Outputs: `bus_out`={4'b0, `addr`}, `control_word_out`=1<<`MAR_IN_BIT`, `busy`=1.
  - Next state is always DATA.
- DATA:
  - Outputs: `bus_out`=`prog_word`, `control_word_out`=1<<`RAM_IN_BIT`, `busy`=1.
  - If `addr`==`last`, go to HANDOFF. Otherwise increment `addr` and go to ADDR.
- HANDOFF:
  - Outputs: `cpu_clear`=1, `control_word_out`=0, `bus_out`=z, `busy`=1, `decoder_enable`=0.
  - Next state is always RUN.
- RUN:
  - Outputs: `decoder_enable`=1, `control_word_out`=z, `bus_out`=z, `done`=1.
  - On `start`=1: latch the length, clear `addr`, and go to ADDR (or HANDOFF if the length is 0). `decoder_enable` drops at that same edge.
- `start` is ignored in ADDR, DATA and HANDOFF. The latched length is not re-sampled mid-load.
- `prog_addr`=`addr` in every state. In IDLE and RUN it reads 0 after a latch, otherwise it holds its last value.
- Exactly one control-word bit is set in ADDR and DATA. No other bits are ever asserted by this block.

## Timing
- Reset: state=IDLE, `addr`=0, `last`=0, `empty`=0, `decoder_enable`=0, `cpu_clear`=0, `busy`=0, `done`=0, `control_word_out`=0, `bus_out`=z.
- Latency:
  - `start` at edge k puts the block in ADDR during cycle k+1.
  - N bytes (1..16) take 2N cycles of ADDR/DATA, then 1 HANDOFF cycle.
  - `decoder_enable`=1 from cycle k+2N+2.
- Length 0: HANDOFF in cycle k+1, RUN in cycle k+2. No RAM writes occur.
- Length 16: `addr` runs from 0 to 15 with no wrap, and the final DATA writes address 15.
- `clear` mid-load: the block returns to IDLE asynchronously. The bus and control word release immediately and `decoder_enable`=0. RAM contents already written are left as is.
- `start` held high through a load: it is not re-sampled until RUN. If still high at the first RUN edge, a reload begins after exactly one RUN cycle.
- The decoder never sees `enable`=1 while the loader drives `control_word_out`, so there is no overlap on the shared nets.

## Test plan
- Reset, then `start` with length 3 and source bytes {0x1E, 0x2F, 0xE0} -> the bus/control sequence is (0x00, MAR), (0x1E, RAM), (0x01, MAR), (0x2F, RAM), (0x02, MAR), (0xE0, RAM). Then `cpu_clear` for 1 cycle, then `decoder_enable`=1 at cycle k+8.
- Length 0 -> no MAR/RAM bits ever set. `cpu_clear` in cycle k+1, `done`=1 at cycle k+2.
- Length 20 -> clamped to 16. The last write is at `prog_addr`=15 and `decoder_enable` rises at cycle k+34.
- `clear` pulsed during DATA of byte 2 -> immediate IDLE, `bus_out`=z, `control_word_out`=0, `busy`=0. A following `start` restarts at address 0.
- `start` in RUN with length 1 -> `decoder_enable` falls at the sampling edge. Then one (MAR, RAM) pair, a `cpu_clear` pulse, and RUN again.
- `start` pulsed during ADDR -> ignored, and the length is unchanged.
